round_sequencer: RTL

ROUND_SEQUENCER -- requirements
Module: round_sequencer

---
 rtl/round_sequencer_pkg.sv | 26 ++
 rtl/round_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/round_sequencer_pkg.sv
// rtl/round_sequencer_pkg.sv - shared constants and state encoding for the round sequencer
//
// Purpose : single source for the round-index width, the parameter defaults
//           and the FSM state encoding used by round_sequencer.
// Ports   : none (package).
// Config  : ROUND_SEQ_ABORT_EN is consumed by round_sequencer.sv, not here.

package round_sequencer_pkg;

  // Width of the index driven to the Round_Constants lookup.
  localparam int IDX_W = 4;

  // Defaults for the top-level parameters.
  localparam int ROUNDS_DEF = 12;
  localparam int RC_W_DEF   = 128;

  // FSM encoding.
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_FETCH = 2'd1;
  localparam logic [STATE_W-1:0] S_HOLD  = 2'd2;
  localparam logic [STATE_W-1:0] S_DONE  = 2'd3;

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - issues ROUNDS round constants from an external lookup, one per handshake
//
// Purpose : walks round_counter 1..ROUNDS, registers the constant the lookup
//           returns for each index and holds it until downstream accepts it.
// Ports   :
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          begin a run (honoured only when idle)
//   abort          (ROUND_SEQ_ABORT_EN only) drop the current run
//   round_counter  index to the Round_Constants lookup (register output)
//   rc_in          constant returned by the lookup for round_counter
//   rc_out         registered constant for the key-schedule stage
//   rc_valid       rc_out is valid
//   rc_ready       downstream accepts rc_out when rc_valid && rc_ready
//   last           rc_out is the final constant of the run
//   busy           sequencer is not idle
//   done           one-cycle pulse after the final constant is accepted
// Config  : define ROUND_SEQ_ABORT_EN to add the abort input.

module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int RC_W   = RC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef ROUND_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [IDX_W-1:0] round_counter,
  input  logic [RC_W-1:0]  rc_in,
  output logic [RC_W-1:0]  rc_out,
  output logic             rc_valid,
  input  logic             rc_ready,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS);

  logic [STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [RC_W-1:0]    rc_q, rc_d;
  logic               valid_q, valid_d;
  logic               abort_w;

`ifdef ROUND_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    valid_d = valid_q;

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        valid_d = 1'b0;
        if (start) begin
          cnt_d   = IDX_W'(1);
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (abort_w) begin
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          // The lookup answers combinationally for cnt_q, so capture it now.
          rc_d    = rc_in;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (abort_w) begin
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (rc_ready) begin
          // valid_q is always set in HOLD, so rc_ready alone is the handshake.
          valid_d = 1'b0;
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + IDX_W'(1);
            state_d = S_FETCH;
          end
        end
      end

      S_DONE: begin
        // Any start seen here is dropped; the run must return to IDLE first.
        cnt_d   = '0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      valid_q <= valid_d;
    end
  end

  assign round_counter = cnt_q;
  assign rc_out        = rc_q;
  assign rc_valid      = valid_q;
  assign last          = valid_q && (cnt_q == LAST_IDX);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

endmodule
